// File: rtl/dc_offset_loop_if.sv
// Bundle of the DC-offset loop's control, accumulator and sample-stream signals.
// The master side drives the loop inputs; the slave side is the canceller itself.
interface dc_offset_loop_if;
  logic               clk_en;
  logic               enable;
  logic               freeze;
  logic               corr_clear;
  logic signed [17:0] acc_mean_in;
  logic signed [17:0] sig_in;
  logic               hold;
  logic               clear;
  logic signed [17:0] dc_corr;
  logic signed [17:0] sig_out;
  logic               corr_valid;
  logic [15:0]        win_count;

  modport master (
    output clk_en, enable, freeze, corr_clear, acc_mean_in, sig_in,
    input  hold, clear, dc_corr, sig_out, corr_valid, win_count
  );

  modport slave (
    input  clk_en, enable, freeze, corr_clear, acc_mean_in, sig_in,
    output hold, clear, dc_corr, sig_out, corr_valid, win_count
  );
endinterface

// File: rtl/dc_offset_loop.sv
// Closed-loop DC-offset canceller: sequences accumulator windows via hold/clear,
// integrates the window mean into a saturating correction, subtracts it per symbol.
module dc_offset_loop #(
  parameter int WIN_LOG2 = 20,
  parameter int MU_SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset,
  dc_offset_loop_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_GUARD  = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  localparam int CW = WIN_LOG2 + 1;
  localparam logic [CW-1:0] WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               hold_q, hold_d;
  logic               clear_q, clear_d;
  logic signed [17:0] dc_corr_q, dc_corr_d;
  logic signed [17:0] sig_out_q, sig_out_d;
  logic               corr_valid_q, corr_valid_d;
  logic [15:0]        win_count_q, win_count_d;

  logic signed [17:0] step;
  logic signed [18:0] corr_sum;
  logic signed [18:0] sig_diff;
  logic [CW-1:0]      cnt_inc;

  // Clamp a 19-bit result into the 18-bit signed range; overflow shows as bit 18 != bit 17.
  function automatic logic signed [17:0] sat18(input logic signed [18:0] v);
    if (v[18] != v[17]) return v[18] ? 18'sh20000 : 18'sh1ffff;
    else                return v[17:0];
  endfunction

  assign step     = bus.acc_mean_in >>> MU_SHIFT;
  assign corr_sum = $signed({dc_corr_q[17], dc_corr_q}) + $signed({step[17], step});
  assign sig_diff = $signed({bus.sig_in[17], bus.sig_in}) - $signed({dc_corr_q[17], dc_corr_q});
  assign cnt_inc  = cnt_q + 1'b1;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dc_corr_d    = dc_corr_q;
    sig_out_d    = sig_out_q;
    corr_valid_d = 1'b0;
    win_count_d  = win_count_q;

    if (!bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACCUM;
          cnt_d   = '0;
        end
        S_ACCUM, S_UPDATE: begin
          if (state_q == S_UPDATE) begin
            state_d     = S_ACCUM;
            win_count_d = win_count_q + 16'd1;
            if (!bus.freeze) begin
              dc_corr_d    = sat18(corr_sum);
              corr_valid_d = 1'b1;
            end
          end
          // A strobe landing in UPDATE is already symbol 1 of the next window.
          if (bus.clk_en) begin
            cnt_d = cnt_inc;
            if (cnt_inc == WIN_LEN) state_d = S_GUARD;
          end
        end
        S_GUARD: begin
          if (bus.clk_en) begin
            cnt_d   = '0;
            state_d = S_UPDATE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (bus.corr_clear) begin
      dc_corr_d    = '0;
      corr_valid_d = 1'b0;
    end

    if (bus.clk_en) sig_out_d = sat18(sig_diff);

    // hold/clear are registered from the next state so they are glitch-free to the accumulator.
    hold_d  = (state_d == S_GUARD);
    clear_d = (state_d == S_IDLE) || (state_d == S_GUARD);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hold_q       <= 1'b0;
      clear_q      <= 1'b1;
      dc_corr_q    <= '0;
      sig_out_q    <= '0;
      corr_valid_q <= 1'b0;
      win_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      clear_q      <= clear_d;
      dc_corr_q    <= dc_corr_d;
      sig_out_q    <= sig_out_d;
      corr_valid_q <= corr_valid_d;
      win_count_q  <= win_count_d;
    end
  end

  assign bus.hold       = hold_q;
  assign bus.clear      = clear_q;
  assign bus.dc_corr    = dc_corr_q;
  assign bus.sig_out    = sig_out_q;
  assign bus.corr_valid = corr_valid_q;
  assign bus.win_count  = win_count_q;

endmodule

// File: tb/tb_dc_offset_loop.sv
// Directed bench for dc_offset_loop: two instances (MU_SHIFT=2 and MU_SHIFT=0), WIN_LOG2=4,
// so each window is 16 summed strobes plus one guard strobe.
module tb_dc_offset_loop;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dc_offset_loop_if ifa ();
  dc_offset_loop_if ifb ();

  dc_offset_loop #(.WIN_LOG2(4), .MU_SHIFT(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  dc_offset_loop #(.WIN_LOG2(4), .MU_SHIFT(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit past the edge, away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_clk_en(input bit sel, input logic v);
    if (sel) ifb.clk_en = v;
    else     ifa.clk_en = v;
  endtask

  // One strobe followed by one idle clock.
  task automatic strobe(input bit sel);
    set_clk_en(sel, 1'b1);
    tick();
    set_clk_en(sel, 1'b0);
    tick();
  endtask

  // Full window from counter 0: 16 summed strobes, guard strobe, then the UPDATE clock.
  // Returns 1 unit after the edge where dc_corr/corr_valid change.
  task automatic run_window(input bit sel, input bit clr_at_update);
    for (int i = 0; i < 15; i++) strobe(sel);
    check("hold_before_16th", sel ? ifb.hold : ifa.hold, 0);
    strobe(sel);
    check("hold_after_16th", sel ? ifb.hold : ifa.hold, 1);
    check("clear_in_guard", sel ? ifb.clear : ifa.clear, 1);
    set_clk_en(sel, 1'b1);
    tick();
    set_clk_en(sel, 1'b0);
    check("hold_drop_after_guard", sel ? ifb.hold : ifa.hold, 0);
    check("clear_drop_after_guard", sel ? ifb.clear : ifa.clear, 0);
    if (clr_at_update) ifa.corr_clear = 1'b1;
    tick();
    ifa.corr_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifa.clk_en = 0; ifa.enable = 1; ifa.freeze = 0; ifa.corr_clear = 0;
    ifa.acc_mean_in = 18'sd1000; ifa.sig_in = '0;
    ifb.clk_en = 0; ifb.enable = 1; ifb.freeze = 0; ifb.corr_clear = 0;
    ifb.acc_mean_in = '0; ifb.sig_in = '0;
    tick();
    tick();

    check("rst_hold", ifa.hold, 0);
    check("rst_clear", ifa.clear, 1);
    check("rst_dc_corr", ifa.dc_corr, 0);
    check("rst_sig_out", ifa.sig_out, 0);
    check("rst_corr_valid", ifa.corr_valid, 0);
    check("rst_win_count", ifa.win_count, 0);

    reset = 1'b0;
    tick();

    // Basic update: 1000 >>> 2 = 250.
    run_window(0, 0);
    check("w1_dc_corr", ifa.dc_corr, 250);
    check("w1_corr_valid", ifa.corr_valid, 1);
    check("w1_win_count", ifa.win_count, 1);
    tick();
    check("w1_corr_valid_fall", ifa.corr_valid, 0);

    // sig_out keeps running in IDLE: 1000 - 250 = 750, one strobe of latency.
    ifa.enable = 1'b0;
    tick();
    check("idle_clear", ifa.clear, 1);
    check("sig_out_before", ifa.sig_out, 0);
    ifa.sig_in = 18'sd1000;
    strobe(0);
    check("sig_out_after", ifa.sig_out, 750);
    check("idle_dc_corr_kept", ifa.dc_corr, 250);
    ifa.sig_in = '0;
    ifa.enable = 1'b1;
    tick();

    run_window(0, 0);
    check("w2_dc_corr", ifa.dc_corr, 500);
    check("w2_win_count", ifa.win_count, 2);

    // corr_clear alone zeroes the correction without touching the window count.
    ifa.corr_clear = 1'b1;
    tick();
    ifa.corr_clear = 1'b0;
    check("corr_clear_dc_corr", ifa.dc_corr, 0);
    check("corr_clear_win_count", ifa.win_count, 2);

    // Negative floor: -3 >>> 2 = -1 per window.
    ifa.acc_mean_in = -18'sd3;
    run_window(0, 0);
    check("neg_w1", ifa.dc_corr, -1);
    run_window(0, 0);
    check("neg_w2", ifa.dc_corr, -2);
    run_window(0, 0);
    check("neg_w3", ifa.dc_corr, -3);
    check("neg_win_count", ifa.win_count, 5);

    // Freeze: windows run and count, correction stays put.
    ifa.freeze = 1'b1;
    ifa.acc_mean_in = 18'sd1000;
    for (int w = 0; w < 3; w++) begin
      run_window(0, 0);
      check("frz_corr_valid", ifa.corr_valid, 0);
      check("frz_dc_corr", ifa.dc_corr, -3);
    end
    check("frz_win_count", ifa.win_count, 8);
    ifa.freeze = 1'b0;

    // Clear priority: -3 + (2012 >>> 2) = 500, then corr_clear lands on UPDATE.
    ifa.acc_mean_in = 18'sd2012;
    run_window(0, 0);
    check("pre_clr_dc_corr", ifa.dc_corr, 500);
    check("pre_clr_win_count", ifa.win_count, 9);
    run_window(0, 1);
    check("clr_prio_dc_corr", ifa.dc_corr, 0);
    check("clr_prio_win_count", ifa.win_count, 10);

    // Reset at strobe 9 of a window: outputs return to reset values without a clock.
    ifa.acc_mean_in = 18'sd1000;
    for (int i = 0; i < 9; i++) strobe(0);
    reset = 1'b1;
    #1;
    check("midrst_hold", ifa.hold, 0);
    check("midrst_clear", ifa.clear, 1);
    check("midrst_win_count", ifa.win_count, 0);
    check("midrst_dc_corr", ifa.dc_corr, 0);
    check("midrst_sig_out", ifa.sig_out, 0);
    tick();
    reset = 1'b0;
    tick();
    run_window(0, 0);
    check("postrst_dc_corr", ifa.dc_corr, 250);
    check("postrst_win_count", ifa.win_count, 1);

    // Drop enable in GUARD: no update, no count, clear asserted.
    for (int i = 0; i < 16; i++) strobe(0);
    check("abort_in_guard", ifa.hold, 1);
    ifa.enable = 1'b0;
    tick();
    check("abort_hold", ifa.hold, 0);
    check("abort_clear", ifa.clear, 1);
    strobe(0);
    check("abort_dc_corr", ifa.dc_corr, 250);
    check("abort_win_count", ifa.win_count, 1);
    check("abort_corr_valid", ifa.corr_valid, 0);
    ifa.enable = 1'b1;
    tick();
    run_window(0, 0);
    check("after_abort_dc_corr", ifa.dc_corr, 500);
    check("after_abort_win_count", ifa.win_count, 2);

    // Positive saturation on the MU_SHIFT=0 instance.
    ifb.acc_mean_in = 18'sd131000;
    run_window(1, 0);
    check("sat_preload", ifb.dc_corr, 131000);
    ifb.acc_mean_in = 18'sd131071;
    run_window(1, 0);
    check("sat_dc_corr", ifb.dc_corr, 131071);
    ifb.sig_in = -18'sd131072;
    strobe(1);
    check("sat_sig_out", ifb.sig_out, -131072);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dc_offset_loop.md
# dc_offset_loop

Closed-loop DC-offset canceller that sits directly downstream of the DC-error accumulator. It sequences the accumulator's measurement windows by driving its `hold`/`clear` inputs, and reads back the window-mean error. It integrates that mean into a saturating correction register. It subtracts the correction from the receive sample stream at symbol rate.

## Interface
- `WIN_LOG2`, default 20: log2 of the number of summed symbols per window. Must equal the accumulator's truncation width, so that its held output is the window mean.
- `MU_SHIFT`, default 4: loop gain as a right shift applied to the window mean (range 0–17).
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high. Clears all state.
- `clk_en`  in  1: symbol-rate enable, the same strobe that feeds the accumulator.
- `enable`  in  1: loop enable. Low forces IDLE.
- `freeze`  in  1: windows keep running, but correction updates are suppressed.
- `corr_clear`  in  1: synchronous; zeroes `dc_corr`.
- `acc_mean_in`  in  18 signed: held window mean from the accumulator.
- `sig_in`  in  18 signed: receive sample, valid on `clk_en`.
- `hold`  out  1: to the accumulator; latch the window sum.
- `clear`  out  1: to the accumulator; empty the running sum.
- `dc_corr`  out  18 signed: current correction value.
- `sig_out`  out  18 signed: `sig_in − dc_corr`, saturated and registered.
- `corr_valid`  out  1: one-clk pulse when `dc_corr` updates.
- `win_count`  out  16: completed windows, wraps at 65535→0.

## Operation
- **Window structure:** 2^WIN_LOG2 summed symbols plus 1 guard symbol, so the period is 2^WIN_LOG2+1 `clk_en` strobes. The guard sample is discarded because `clear` dominates accumulation in the accumulator.
- **FSM states:** IDLE, ACCUM, GUARD, UPDATE.
- **IDLE:**
  - Entered on reset, or from any state when `enable` is low. `enable` low has priority over every other transition.
  - `clear`=1, `hold`=0, symbol counter=0.
  - `dc_corr` is retained; `sig_out` keeps running.
  - Leaves to ACCUM on the first clk with `enable`=1.
- **ACCUM:** `clear`=0, `hold`=0. The counter increments on each `clk_en`. The edge on which the counter reaches 2^WIN_LOG2 moves to GUARD.
- **GUARD:**
  - `hold`=1, `clear`=1 (both registered, both asserted for the whole state).
  - On the next `clk_en` edge (the guard edge), the accumulator latches its sum. The FSM resets the counter to 0 and moves to UPDATE.
- **UPDATE:** lasts exactly 1 clk.
  - Samples `acc_mean_in`.
  - If `freeze`=0: `dc_corr ← sat18(dc_corr + (acc_mean_in >>> MU_SHIFT))`.
  - `corr_valid` pulses only when `freeze`=0. `win_count` increments regardless of `freeze`.
  - Moves to ACCUM.
  - A `clk_en` arriving during UPDATE counts as symbol 1 of the new window.
- **Arithmetic rules:**
  - The shift is arithmetic (floor), so −3>>>2 = −1.
  - The sum is computed at 19 bits, then saturated to [−131072, 131071].
  - `sig_out` uses the same 19-bit subtract and saturation.
- **`corr_clear`:** zeroes `dc_corr` on the next edge and overrides an UPDATE in the same cycle. It does not disturb the FSM.

## Timing
- **Reset values:** `hold`=0, `clear`=1, `dc_corr`=0, `sig_out`=0, `corr_valid`=0, `win_count`=0, state IDLE.
- **`sig_out`:** registered on `clk_en` with 1-strobe latency. It uses the `dc_corr` value present at that edge.
- **Update timing:** for a guard edge at E0:
  - `hold` and `clear` drop after E0.
  - `dc_corr` and `corr_valid` change at E0+1.
  - `corr_valid` is high for exactly clk E0+1..E0+2.
- **`hold` rise:** `hold` rises the clk after the 2^WIN_LOG2-th summed strobe, before the guard strobe. `clk_en` must have at least one idle clk between strobes.
- **Reset mid-window:** returns to IDLE immediately. The partial window is discarded, because `clear` asserts asynchronously with reset.
- **`enable` drop in GUARD or UPDATE:** aborts with no update and no `win_count` increment.
- **`freeze` timing:** `freeze` is sampled only in UPDATE.

## Test plan
- **Basic update:** WIN_LOG2=4, MU_SHIFT=2, `acc_mean_in`=1000 held. Expect after the first window: `dc_corr`=250, one `corr_valid` pulse, `win_count`=1, `hold` high for exactly one guard strobe, 17 strobes per window.
- **Positive saturation:** preload `dc_corr`=131000, `acc_mean_in`=131071, MU_SHIFT=0. Expect `dc_corr`=131071, no wrap. Then `sig_in`=−131072 gives `sig_out`=−131072 (saturated).
- **Negative floor:** `acc_mean_in`=−3, MU_SHIFT=2. Expect `dc_corr` to step −1 per window (−1, −2, −3 …).
- **Freeze:** `freeze`=1 across three windows. Expect `dc_corr` unchanged, `corr_valid` never high, `win_count`=3.
- **Reset and enable abort:** assert `reset` at strobe 9 of the window. Expect all outputs at reset values immediately, and a full 17-strobe window after release. Separately, drop `enable` during GUARD: expect no update and `clear`=1.
- **Clear priority:** `corr_clear` in the same clk as UPDATE with `dc_corr`=500. Expect `dc_corr`=0, `win_count` incremented.
